// File: rtl/ex_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_alu_stage
// Execute stage of the pipeline: picks forwarded operands, computes a
// DataW-bit ALU result, owns the condition-code register (CCR = {C,N,Z})
// together with a one-deep saved-CCR slot for interrupts, and resolves
// conditional jumps against the current CCR.
//
// Ports
//   clk, rst (sync, active-low), enable (0 = stall CCR/saved CCR)
//   i_read_data1/2, i_immd, i_Rsrc1/2    : operands and their addresses
//   i_alu_op, i_alu_src, i_flag_en       : operation control
//   i_flag_restore, in_INT               : RTI restore / interrupt save
//   i_jmp_cond, i_jmp_uncond             : jump control
//   i_mem_*, i_wb_*                      : forwarding sources
//   o_result, o_store_data, o_jump_taken, o_jump_target : combinational
//   o_ccr                                : registered {C,N,Z}
// ---------------------------------------------------------------------------
module ex_alu_stage #(
   parameter int DataW    = 16,
   parameter int PcW      = 32,
   parameter int RegAddrW = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [DataW-1:0]    i_read_data1,
   input  logic [DataW-1:0]    i_read_data2,
   input  logic [DataW-1:0]    i_immd,
   input  logic [RegAddrW-1:0] i_Rsrc1,
   input  logic [RegAddrW-1:0] i_Rsrc2,
   input  logic [3:0]          i_alu_op,
   input  logic                i_alu_src,
   input  logic                i_flag_en,
   input  logic                i_flag_restore,
   input  logic [1:0]          i_jmp_cond,
   input  logic                i_jmp_uncond,
   input  logic                in_INT,
   input  logic                i_mem_wb_en,
   input  logic [RegAddrW-1:0] i_mem_Rdst,
   input  logic [DataW-1:0]    i_mem_result,
   input  logic                i_wb_en,
   input  logic [RegAddrW-1:0] i_wb_Rdst,
   input  logic [DataW-1:0]    i_wb_result,
   output logic [DataW-1:0]    o_result,
   output logic [DataW-1:0]    o_store_data,
   output logic [2:0]          o_ccr,
   output logic                o_jump_taken,
   output logic [PcW-1:0]      o_jump_target
);

   localparam logic [3:0] OP_SETC = 4'b0001;
   localparam logic [3:0] OP_CLRC = 4'b0010;
   localparam logic [3:0] OP_NOT  = 4'b0011;
   localparam logic [3:0] OP_INC  = 4'b0100;
   localparam logic [3:0] OP_DEC  = 4'b0101;
   localparam logic [3:0] OP_MOV  = 4'b0110;
   localparam logic [3:0] OP_ADD  = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_OR   = 4'b1010;
   localparam logic [3:0] OP_SHL  = 4'b1011;
   localparam logic [3:0] OP_SHR  = 4'b1100;

   logic [2:0]       ccr_q, ccr_d;
   logic [2:0]       saved_q, saved_d;
   logic [DataW-1:0] fwd_a_s, fwd_b_s, opb_s, result_s;
   logic             upd_zn_s, upd_c_s, c_val_s;
   logic             cond_true_s;
   logic [2:0]       clr_mask_s, flags_s;

   // Wide intermediates: the extra MSB (or LSB for SHR) carries C.
   logic [DataW:0]   sum_s, diff_s, inc_s, dec_s, shl_s, shr_s;
   logic [3:0]       shamt_s;

   // Operand forwarding: memory stage has priority over write-back.
   always_comb begin
      fwd_a_s = i_read_data1;
      fwd_b_s = i_read_data2;
      if (i_mem_wb_en && (i_mem_Rdst == i_Rsrc1)) begin
         fwd_a_s = i_mem_result;
      end else if (i_wb_en && (i_wb_Rdst == i_Rsrc1)) begin
         fwd_a_s = i_wb_result;
      end else begin
         fwd_a_s = i_read_data1;
      end
      if (i_mem_wb_en && (i_mem_Rdst == i_Rsrc2)) begin
         fwd_b_s = i_mem_result;
      end else if (i_wb_en && (i_wb_Rdst == i_Rsrc2)) begin
         fwd_b_s = i_wb_result;
      end else begin
         fwd_b_s = i_read_data2;
      end
   end

   assign opb_s   = i_alu_src ? i_immd : fwd_b_s;
   assign shamt_s = opb_s[3:0];
   assign sum_s   = {1'b0, fwd_a_s} + {1'b0, opb_s};
   assign diff_s  = {1'b0, fwd_a_s} - {1'b0, opb_s};
   assign inc_s   = {1'b0, fwd_a_s} + {{DataW{1'b0}}, 1'b1};
   assign dec_s   = {1'b0, fwd_a_s} - {{DataW{1'b0}}, 1'b1};
   assign shl_s   = {1'b0, fwd_a_s} << shamt_s;
   assign shr_s   = {fwd_a_s, 1'b0} >> shamt_s;

   // ALU result and which flags the operation wants to write.
   always_comb begin
      result_s = fwd_a_s;
      upd_zn_s = 1'b0;
      upd_c_s  = 1'b0;
      c_val_s  = 1'b0;
      case (i_alu_op)
         OP_SETC: begin upd_c_s = 1'b1; c_val_s = 1'b1; end
         OP_CLRC: begin upd_c_s = 1'b1; c_val_s = 1'b0; end
         OP_NOT:  begin result_s = ~fwd_a_s; upd_zn_s = 1'b1; end
         OP_INC:  begin result_s = inc_s[DataW-1:0]; upd_zn_s = 1'b1;
                        upd_c_s = 1'b1; c_val_s = inc_s[DataW]; end
         OP_DEC:  begin result_s = dec_s[DataW-1:0]; upd_zn_s = 1'b1;
                        upd_c_s = 1'b1; c_val_s = dec_s[DataW]; end
         OP_MOV:  begin result_s = opb_s; end
         OP_ADD:  begin result_s = sum_s[DataW-1:0]; upd_zn_s = 1'b1;
                        upd_c_s = 1'b1; c_val_s = sum_s[DataW]; end
         OP_SUB:  begin result_s = diff_s[DataW-1:0]; upd_zn_s = 1'b1;
                        upd_c_s = 1'b1; c_val_s = diff_s[DataW]; end
         OP_AND:  begin result_s = fwd_a_s & opb_s; upd_zn_s = 1'b1; end
         OP_OR:   begin result_s = fwd_a_s | opb_s; upd_zn_s = 1'b1; end
         // A zero shift amount leaves C untouched.
         OP_SHL:  begin result_s = shl_s[DataW-1:0]; upd_zn_s = 1'b1;
                        upd_c_s = (shamt_s != 4'd0); c_val_s = shl_s[DataW]; end
         OP_SHR:  begin result_s = shr_s[DataW:1]; upd_zn_s = 1'b1;
                        upd_c_s = (shamt_s != 4'd0); c_val_s = shr_s[0]; end
         default: begin result_s = fwd_a_s; end
      endcase
   end

   // Conditional jump evaluation and the flag it clears when taken.
   always_comb begin
      case (i_jmp_cond)
         2'b01:   begin cond_true_s = ccr_q[0]; clr_mask_s = 3'b001; end
         2'b10:   begin cond_true_s = ccr_q[1]; clr_mask_s = 3'b010; end
         2'b11:   begin cond_true_s = ccr_q[2]; clr_mask_s = 3'b100; end
         default: begin cond_true_s = 1'b0;     clr_mask_s = 3'b000; end
      endcase
   end

   // CCR next state: restore beats ALU update; jump clear beats ALU update.
   always_comb begin
      flags_s = ccr_q;
      if (i_flag_en && upd_zn_s) begin
         flags_s[0] = (result_s == {DataW{1'b0}});
         flags_s[1] = result_s[DataW-1];
      end else begin
         flags_s[1:0] = ccr_q[1:0];
      end
      if (i_flag_en && upd_c_s) begin
         flags_s[2] = c_val_s;
      end else begin
         flags_s[2] = ccr_q[2];
      end
      if (cond_true_s) begin
         flags_s = flags_s & ~clr_mask_s;
      end else begin
         flags_s = flags_s;
      end
      if (i_flag_restore) begin
         ccr_d = saved_q;
      end else begin
         ccr_d = flags_s;
      end
      // Save always captures the pre-edge CCR, which yields a swap with restore.
      if (in_INT) begin
         saved_d = ccr_q;
      end else begin
         saved_d = saved_q;
      end
   end

   // CCR and saved-CCR registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ccr_q   <= 3'b000;
         saved_q <= 3'b000;
      end else if (enable) begin
         ccr_q   <= ccr_d;
         saved_q <= saved_d;
      end else begin
         ccr_q   <= ccr_q;
         saved_q <= saved_q;
      end
   end

   assign o_result      = result_s;
   assign o_store_data  = fwd_b_s;
   assign o_ccr         = ccr_q;
   assign o_jump_taken  = i_jmp_uncond | cond_true_s;
   assign o_jump_target = {{(PcW-DataW){1'b0}}, fwd_a_s};

endmodule
